// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: walks each instruction through fetch/decode/execute/memory/writeback
// over one shared memory port, with a memory-latency watchdog, halt/fault states and a retired-instruction count.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 pc_write_en,
  output logic                 pc_src,
  output logic                 ir_write_en,
  output logic                 adr_src,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic                 reg_write_en,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic [2:0]           imm_src,
  output logic                 branch,
  output logic                 halted,
  output logic                 fault,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_AUIPC = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11,
    S_JALR = 4'd12, S_LUI = 4'd13, S_HALT = 4'd14, S_FAULT = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Counter only has to reach MEM_TIMEOUT-1; with the watchdog disabled it may wrap harmlessly.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            cur_state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait, timed_out, retire;

  function automatic logic [2:0] imm_for(input logic [6:0] op);
    case (op)
      OP_STORE:          imm_for = 3'b001;
      OP_BRANCH:         imm_for = 3'b010;
      OP_JAL:            imm_for = 3'b011;
      OP_LUI, OP_AUIPC:  imm_for = 3'b100;
      default:           imm_for = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
      instret   <= '0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= (mem_wait && !timed_out) ? wait_cnt + WAIT_W'(1) : '0;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    next_state = cur_state;
    mem_wait   = 1'b0;
    retire     = 1'b0;
    case (cur_state)
      S_FETCH: begin
        if (run) begin
          if (mem_ready) next_state = S_DECODE;
          else           mem_wait   = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_AUIPC;
          OP_SYSTEM:         next_state = S_HALT;
          default:           next_state = S_FAULT;
        endcase
      end
      S_MEMADR:  next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready) next_state = S_MEMWB;
        else           mem_wait   = 1'b1;
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_EXECR, S_EXECI, S_AUIPC: next_state = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      default: next_state = cur_state;
    endcase
    timed_out = mem_wait && (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    if (timed_out) next_state = S_FAULT;
  end

  always_comb begin
    pc_write_en  = 1'b0;
    pc_src       = 1'b0;
    ir_write_en  = 1'b0;
    adr_src      = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    reg_write_en = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    result_src   = 2'b00;
    imm_src      = 3'b000;
    branch       = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    if (rst_n) begin
      // Immediate format is held for the whole instruction so MEMADR/EXECI/JALR/LUI/AUIPC see the right imm.
      if (cur_state != S_FETCH && cur_state != S_HALT && cur_state != S_FAULT) imm_src = imm_for(opcode);
      case (cur_state)
        S_FETCH: begin
          if (run) begin
            mem_read_en = 1'b1;
            alu_src_b   = 2'b10;
            if (mem_ready) begin
              ir_write_en = 1'b1;
              pc_write_en = 1'b1;
            end
          end
        end
        S_DECODE, S_AUIPC: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_read_en = 1'b1;
          adr_src     = 1'b1;
        end
        S_MEMWB: begin
          reg_write_en = 1'b1;
          result_src   = 2'b01;
        end
        S_MEMWRITE: begin
          mem_write_en = 1'b1;
          adr_src      = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: reg_write_en = 1'b1;
        S_BRANCH: begin
          branch      = 1'b1;
          alu_src_a   = 2'b10;
          alu_op      = 2'b01;
          pc_src      = 1'b1;
          pc_write_en = branch_taken;
        end
        S_JAL: begin
          reg_write_en = 1'b1;
          result_src   = 2'b10;
          pc_write_en  = 1'b1;
          pc_src       = 1'b1;
        end
        S_JALR: begin
          alu_src_a    = 2'b10;
          alu_src_b    = 2'b01;
          reg_write_en = 1'b1;
          result_src   = 2'b10;
          pc_write_en  = 1'b1;
        end
        S_LUI: begin
          reg_write_en = 1'b1;
          result_src   = 2'b11;
        end
        S_HALT: halted = 1'b1;
        S_FAULT: begin
          halted = 1'b1;
          fault  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: walks instruction classes, memory stalls, the watchdog,
// halt/fault and asynchronous reset, comparing against hand-computed control values.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n, run, mem_ready, branch_taken;
  logic [6:0]  opcode;
  logic        pc_write_en, pc_src, ir_write_en, adr_src, mem_read_en, mem_write_en, reg_write_en;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0]  imm_src;
  logic        branch, halted, fault;
  logic [3:0]  state;
  logic [31:0] instret;

  int nvec = 0;
  int nmis = 0;
  int exp_ret = 0;

  typedef struct packed {
    logic [6:0] op;
    logic [3:0] st;
    logic [2:0] imm;
    logic       pcw;
  } vec_t;

  vec_t tbl [5] = '{
    '{7'b0010011, 4'd7,  3'b000, 1'b0},
    '{7'b0010111, 4'd8,  3'b100, 1'b0},
    '{7'b1101111, 4'd11, 3'b011, 1'b1},
    '{7'b1100111, 4'd12, 3'b000, 1'b1},
    '{7'b0110111, 4'd13, 3'b100, 1'b0}
  };

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .run(run), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write_en(pc_write_en), .pc_src(pc_src),
    .ir_write_en(ir_write_en), .adr_src(adr_src), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .reg_write_en(reg_write_en), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
    .branch(branch), .halted(halted), .fault(fault), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  // Leaves the FSM in DECODE with checks done; caller may add more checks in that phase.
  task automatic fetch_decode(input logic [6:0] op);
    opcode = op;
    run = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_vec("fd_fetch_state", state, 0);
    check_vec("fd_ir_write", ir_write_en, 1);
    tick();
    #1;
    check_vec("fd_decode_state", state, 1);
  endtask

  task automatic run_to_fetch(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (state == 4'd0) break;
      tick();
    end
    check_vec("return_to_fetch", state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    run = 1'b1;
    mem_ready = 1'b1;
    branch_taken = 1'b0;
    opcode = 7'b0110011;
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_state", state, 0);
    check_vec("rst_mem_read", mem_read_en, 0);
    check_vec("rst_ir_write", ir_write_en, 0);
    check_vec("rst_pc_write", pc_write_en, 0);
    check_vec("rst_instret", instret, 0);
    check_vec("rst_halted_fault", {halted, fault}, 0);
    rst_n = 1'b1;

    // ADD: 0,1,6,9,0
    #1;
    check_vec("add_fetch_rd", mem_read_en, 1);
    check_vec("add_fetch_b", alu_src_b, 2'b10);
    check_vec("add_fetch_pcw", pc_write_en, 1);
    check_vec("add_fetch_regw", reg_write_en, 0);
    tick();
    check_vec("add_decode", {state, alu_src_a, alu_src_b, reg_write_en}, {4'd1, 2'b01, 2'b01, 1'b0});
    tick();
    check_vec("add_execr", {state, alu_src_a, alu_src_b, alu_op, reg_write_en}, {4'd6, 2'b10, 2'b00, 2'b10, 1'b0});
    tick();
    check_vec("add_aluwb", {state, reg_write_en, result_src}, {4'd9, 1'b1, 2'b00});
    check_vec("add_instret_pre", instret, 0);
    tick();
    exp_ret++;
    check_vec("add_done", {state, reg_write_en}, {4'd0, 1'b1 & 1'b0});
    check_vec("add_instret", instret, exp_ret);

    // LW with 3-cycle stalls in FETCH and MEMREAD
    opcode = 7'b0000011;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec("lw_fetch_wait", {state, mem_read_en, ir_write_en}, {4'd0, 1'b1, 1'b0});
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_vec("lw_fetch_done", {state, mem_read_en, ir_write_en}, {4'd0, 1'b1, 1'b1});
    tick();
    check_vec("lw_decode", {state, imm_src}, {4'd1, 3'b000});
    mem_ready = 1'b0;
    tick();
    check_vec("lw_memadr", {state, alu_src_a, alu_src_b}, {4'd2, 2'b10, 2'b01});
    tick();
    for (int i = 0; i < 3; i++) begin
      check_vec("lw_memread_wait", {state, mem_read_en, adr_src, mem_write_en}, {4'd3, 1'b1, 1'b1, 1'b0});
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_vec("lw_memread_done", {state, mem_read_en}, {4'd3, 1'b1});
    tick();
    check_vec("lw_memwb", {state, reg_write_en, result_src}, {4'd4, 1'b1, 2'b01});
    tick();
    exp_ret++;
    check_vec("lw_done", state, 0);
    check_vec("lw_instret", instret, exp_ret);

    // BEQ taken then not taken
    for (int t = 1; t >= 0; t--) begin
      fetch_decode(7'b1100011);
      check_vec("beq_imm", imm_src, 3'b010);
      branch_taken = t[0];
      tick();
      check_vec("beq_branch", {state, branch, pc_src, alu_op, pc_write_en}, {4'd10, 1'b1, 1'b1, 2'b01, t[0]});
      tick();
      exp_ret++;
      check_vec("beq_done", state, 0);
      check_vec("beq_instret", instret, exp_ret);
    end
    branch_taken = 1'b0;

    // Remaining instruction classes
    for (int k = 0; k < 5; k++) begin
      fetch_decode(tbl[k].op);
      check_vec("tbl_imm", imm_src, tbl[k].imm);
      tick();
      check_vec("tbl_exec_state", state, tbl[k].st);
      check_vec("tbl_pcw", pc_write_en, tbl[k].pcw);
      run_to_fetch(3);
      exp_ret++;
      check_vec("tbl_instret", instret, exp_ret);
    end

    // SW with mem_ready never arriving: watchdog fault after 4 wait cycles
    fetch_decode(7'b0100011);
    check_vec("sw_imm", imm_src, 3'b001);
    mem_ready = 1'b0;
    tick();
    check_vec("sw_memadr", state, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_vec("sw_wait", {state, mem_write_en, mem_read_en}, {4'd5, 1'b1, 1'b0});
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check_vec("sw_fault", {state, fault, halted, mem_write_en}, {4'd15, 1'b1, 1'b1, 1'b0});
      tick();
    end
    check_vec("sw_fault_instret", instret, exp_ret);

    // SW with mem_ready in the 4th wait cycle retires
    do_reset();
    fetch_decode(7'b0100011);
    mem_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check_vec("sw4_wait", state, 5);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_vec("sw4_accept", {state, mem_write_en}, {4'd5, 1'b1});
    tick();
    exp_ret++;
    check_vec("sw4_done", {state, fault}, {4'd0, 1'b0});
    check_vec("sw4_instret", instret, exp_ret);

    // Illegal opcode
    fetch_decode(7'b1111111);
    tick();
    check_vec("illegal_fault", {state, fault, halted}, {4'd15, 1'b1, 1'b1});

    // ECALL-class opcode halts without fault and without retiring
    do_reset();
    fetch_decode(7'b1110011);
    tick();
    for (int i = 0; i < 12; i++) begin
      check_vec("halt_hold", {state, halted, fault}, {4'd14, 1'b1, 1'b0});
      tick();
    end
    check_vec("halt_instret", instret, 0);

    // Asynchronous reset in the middle of a load
    do_reset();
    fetch_decode(7'b0110011);
    run_to_fetch(4);
    exp_ret++;
    check_vec("pre_rst_instret", instret, exp_ret);
    fetch_decode(7'b0000011);
    mem_ready = 1'b0;
    tick();
    tick();
    check_vec("mid_rd_active", {state, mem_read_en}, {4'd3, 1'b1});
    rst_n = 1'b0;
    #1;
    check_vec("mid_rst_outputs", {mem_read_en, mem_write_en, reg_write_en, adr_src}, 0);
    check_vec("mid_rst_state", state, 0);
    check_vec("mid_rst_instret", instret, 0);
    tick();
    tick();
    rst_n = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_vec("idle_norun", {state, mem_read_en, ir_write_en}, {4'd0, 1'b0, 1'b0});
      tick();
    end
    check_vec("idle_instret", instret, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It replaces the single-cycle control path and shares one unified memory port between instruction fetch and data access. It walks each instruction through fetch, decode, execute, memory and writeback states, driving datapath enables and mux selects. It also handles variable memory latency through a ready handshake, a memory watchdog, halt/fault detection and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory access may wait for mem_ready; 0 disables the watchdog
INSTRET_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]; stable from DECODE until the next FETCH
run  in  1  fetch permit; 0 holds the core in FETCH without issuing
mem_ready  in  1  memory completes the current read/write this cycle
branch_taken  in  1  branch comparator result, valid in BRANCH
pc_write_en  out  1  PC register load
pc_src  out  1  0 = ALU result, 1 = ALUOut register
ir_write_en  out  1  IR/oldPC load
adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read_en  out  1  memory read request
mem_write_en  out  1  memory write request
reg_write_en  out  1  register-file write
alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
result_src  out  2  00 = ALUOut, 01 = mem data, 10 = PC (oldPC+4), 11 = imm
imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
branch  out  1  high in BRANCH
halted  out  1  sticky; set in HALT or FAULT
fault  out  1  sticky; illegal opcode or memory timeout
state  out  4  current state encoding, for debug
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (asynchronous, rst_n=0): state=FETCH, instret=0, wait counter=0. While rst_n is low, every enable, halted and fault are 0.
- Outputs are Moore-decoded from state. Unlisted outputs are 0. Exceptions: ir_write_en and pc_write_en in FETCH, and pc_write_en in BRANCH, are Mealy.
- Opcode-to-imm_src mapping: LOAD/ITYPE/JALR = 000, STORE = 001, BRANCH = 010, JAL = 011, LUI/AUIPC = 100.
- State encodings and actions:
  - FETCH (0): when run=1, drive mem_read_en=1, adr_src=0, a=00, b=10, alu_op=00. When run=1 and mem_ready=1, also drive ir_write_en=1, pc_write_en=1, pc_src=0, and go to DECODE. When run=0, no request is issued and the wait counter is held at 0.
  - DECODE (1): a=01, b=01, alu_op=00 (branch/JAL target into ALUOut). imm_src follows opcode. Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - 1110011 -> HALT
    - anything else -> FAULT
  - MEMADR (2): a=10, b=01, alu_op=00. Go to MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD (3): mem_read_en=1, adr_src=1. On mem_ready, go to MEMWB.
  - MEMWB (4): reg_write_en=1, result_src=01. Go to FETCH; retire.
  - MEMWRITE (5): mem_write_en=1, adr_src=1. On mem_ready, go to FETCH; retire.
  - EXECR (6): a=10, b=00, alu_op=10. Go to ALUWB.
  - EXECI (7): a=10, b=01, alu_op=10. Go to ALUWB.
  - AUIPC (8): a=01, b=01, alu_op=00. Go to ALUWB.
  - ALUWB (9): reg_write_en=1, result_src=00. Go to FETCH; retire.
  - BRANCH (10): branch=1, a=10, b=00, alu_op=01, pc_src=1, pc_write_en=branch_taken. Go to FETCH; retire.
  - JAL (11): reg_write_en=1, result_src=10, pc_write_en=1, pc_src=1. Go to FETCH; retire.
  - JALR (12): a=10, b=01, alu_op=00, reg_write_en=1, result_src=10, pc_write_en=1, pc_src=0. Go to FETCH; retire.
  - LUI (13): reg_write_en=1, result_src=11. Go to FETCH; retire.
  - HALT (14): halted=1. Terminal until reset; not retired.
  - FAULT (15): fault=1, halted=1. Terminal until reset.
- Memory watchdog:
  - The wait counter clears on entry to FETCH, MEMREAD and MEMWRITE. It increments each cycle the state is held with the request active and mem_ready=0.
  - If MEM_TIMEOUT is nonzero and mem_ready is still 0 when the counter equals MEM_TIMEOUT-1, the next state is FAULT.
  - mem_ready arriving in the MEM_TIMEOUT-th cycle of the wait is accepted.
- instret increments by 1 on each retiring transition listed above and wraps modulo 2^INSTRET_W.
- Only one memory request (read or write) is ever asserted per cycle. mem_write_en is never high outside MEMWRITE.
- Reset asserted mid-access forces the reset state immediately. Any in-flight memory transaction is abandoned.

Test Plan:
- ADD x3,x1,x2 (opcode 0110011), mem_ready=1 always -> states 0,1,6,9,0 (4 cycles); reg_write_en high only in ALUWB; instret 0->1.
- LW with mem_ready delayed 3 cycles in both FETCH and MEMREAD -> FETCH held 4 cycles, then states 1,2,3 (held 4 cycles), 4; mem_read_en high throughout each wait; instret=1.
- BEQ: first with branch_taken=1 -> pc_write_en=1, pc_src=1 in state 10; then with branch_taken=0 -> pc_write_en=0; both return to FETCH and retire.
- MEM_TIMEOUT=4, mem_ready held 0 during a SW -> FAULT after 4 wait cycles; fault=halted=1 and mem_write_en=0 in all later cycles. Rerun with mem_ready arriving in cycle 4 -> retires normally.
- Opcode 1111111 -> FAULT directly after DECODE. Opcode 1110011 -> HALT with fault=0, held for 10+ cycles, instret unchanged.
- Assert rst_n=0 mid-MEMREAD -> outputs 0 asynchronously; after release, state=0 and instret=0. run=0 after reset -> mem_read_en=0 and state stays 0.
